fifo_rd_drain: RTL and testbench

- Read-side consumer for the asynchronous FIFO. Lives entirely in the read clock domain.
- Pops words from the FIFO without ever causing underflow and hides the FIFO's one-cycle read latency behind a 2-entry skid buffer.
- Presents the words as a valid/ready stream framed into fixed-length bursts, with out_first/out_last markers.
- Feeds the downstream packet consumer; the FIFO scoreboard checks the same data at this block's output.

---
 rtl/fifo_rd_drain_if.sv | 26 ++
 rtl/fifo_rd_drain.sv | 135 +++++++++++++
 tb/tb_fifo_rd_drain.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_drain_if.sv
// Output stream of the FIFO read-side drain: valid/ready handshake with burst framing.
interface fifo_rd_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_first;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_first,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_first,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-domain FIFO consumer: underflow-free pops, 2-entry skid buffer, fixed-length burst framing.
// Optional running beat/burst totals are enabled by defining FIFO_RD_DRAIN_STATS_EN.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  rd_clk,
  input  logic                  rst,
  input  logic                  drain_en,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_en,
  fifo_rd_drain_if.master       out
`ifdef FIFO_RD_DRAIN_STATS_EN
  ,
  output logic [31:0]           beat_total,
  output logic [15:0]           burst_total
`endif
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_r;
  logic [1:0]            occ_r;
  logic [1:0]            occ_nxt_s;
  logic                  rd_pend_r;
  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [BW-1:0]         beat_r;
  logic [BW-1:0]         beat_nxt_s;
  logic                  out_valid_r;
  logic                  out_first_r;
  logic                  out_last_r;
  logic                  accept_s;
  logic [2:0]            level_s;

  // Occupancy after this edge, counting the word in flight from the FIFO
  always_comb begin
    accept_s  = out_valid_r & out.out_ready;
    level_s   = {1'b0, occ_r} + {2'b00, rd_pend_r} - {2'b00, accept_s};
    occ_nxt_s = level_s[1:0];
    rd_en     = ~rst & drain_en & ~empty & (level_s < 3'd2);
    if (accept_s) begin
      if (beat_r == LAST_BEAT) begin
        beat_nxt_s = '0;
      end else begin
        beat_nxt_s = beat_r + BW'(1);
      end
    end else begin
      beat_nxt_s = beat_r;
    end
  end

  // Skid buffer, beat counter and registered stream outputs
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      occ_r       <= 2'd0;
      rd_pend_r   <= 1'b0;
      head_r      <= '0;
      tail_r      <= '0;
      beat_r      <= '0;
      out_valid_r <= 1'b0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      occ_r     <= occ_nxt_s;
      rd_pend_r <= rd_en;
      if (accept_s) begin
        head_r <= tail_r;
      end
      // A returning word lands in head when head is free or being vacated this edge
      if (rd_pend_r) begin
        if ((occ_r == 2'd0) || ((occ_r == 2'd1) && accept_s)) begin
          head_r <= rdata;
        end else begin
          tail_r <= rdata;
        end
      end
      beat_r      <= beat_nxt_s;
      out_valid_r <= (occ_nxt_s != 2'd0);
      out_first_r <= (occ_nxt_s != 2'd0) && (beat_nxt_s == '0);
      out_last_r  <= (occ_nxt_s != 2'd0) && (beat_nxt_s == LAST_BEAT);
    end
  end

  // Burst framing state; single-beat bursts never leave IDLE
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s && (beat_r == '0) && (BURST_LEN > 1)) begin
            state_r <= BURST;
          end
        end
        BURST: begin
          if (accept_s && out_last_r) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign out.out_valid = out_valid_r;
  assign out.out_data  = head_r;
  assign out.out_first = out_first_r;
  assign out.out_last  = out_last_r;

`ifdef FIFO_RD_DRAIN_STATS_EN
  // Running totals of delivered beats and completed bursts
  always_ff @(posedge rd_clk or posedge rst) begin
    if (rst) begin
      beat_total  <= 32'd0;
      burst_total <= 16'd0;
    end else begin
      if (accept_s) begin
        beat_total <= beat_total + 32'd1;
      end
      if (accept_s && out_last_r) begin
        burst_total <= burst_total + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench: two drains (burst 4 and burst 1) share one FIFO model and are scored against a word-stream reference.
module tb_fifo_rd_drain;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          rd_clk = 1'b0;
  logic          rst = 1'b0;
  logic          drain_en = 1'b0;
  logic          empty = 1'b1;
  logic          out_ready = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          rd_en_a;
  logic          rd_en_b;
`ifdef FIFO_RD_DRAIN_STATS_EN
  logic [31:0]   beat_total_a, beat_total_b;
  logic [15:0]   burst_total_a, burst_total_b;
`endif

  fifo_rd_drain_if #(.DATA_WIDTH(DW)) bus_a ();
  fifo_rd_drain_if #(.DATA_WIDTH(DW)) bus_b ();
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;

  fifo_rd_drain #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut_a (
    .rd_clk   (rd_clk),
    .rst      (rst),
    .drain_en (drain_en),
    .empty    (empty),
    .rdata    (rdata),
    .rd_en    (rd_en_a),
    .out      (bus_a.master)
`ifdef FIFO_RD_DRAIN_STATS_EN
    ,
    .beat_total  (beat_total_a),
    .burst_total (burst_total_a)
`endif
  );

  fifo_rd_drain #(.DATA_WIDTH(DW), .BURST_LEN(1)) dut_b (
    .rd_clk   (rd_clk),
    .rst      (rst),
    .drain_en (drain_en),
    .empty    (empty),
    .rdata    (rdata),
    .rd_en    (rd_en_b),
    .out      (bus_b.master)
`ifdef FIFO_RD_DRAIN_STATS_EN
    ,
    .beat_total  (beat_total_b),
    .burst_total (burst_total_b)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  // Reference: FIFO contents, words popped but not yet delivered, and delivery count
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int vis, pend, n_acc, n_last;
  int n_assert, n_fail, underflow, cyc;
  int obs_acc, obs_last, first_rd, first_val, rel_cyc, acc_mark;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    vis = 0; pend = 0; n_acc = 0; n_last = 0;
  endtask

  task automatic tick();
    logic exp_rd, acc, want_v;
    empty = (fifo_q.size() == 0);
    #1;
    want_v = (vis > 0);
    acc    = want_v && out_ready;
    exp_rd = !rst && drain_en && !empty && ((vis + pend - (acc ? 1 : 0)) < 2);
    check("rd_en_a", {31'd0, rd_en_a}, {31'd0, exp_rd});
    check("rd_en_b", {31'd0, rd_en_b}, {31'd0, exp_rd});
    check("valid_a", {31'd0, bus_a.out_valid}, {31'd0, want_v});
    check("valid_b", {31'd0, bus_b.out_valid}, {31'd0, want_v});
    if (want_v) begin
      check("data_a", {24'd0, bus_a.out_data}, {24'd0, exp_q[0]});
      check("data_b", {24'd0, bus_b.out_data}, {24'd0, exp_q[0]});
      check("first_a", {31'd0, bus_a.out_first}, ((n_acc % BL) == 0) ? 32'd1 : 32'd0);
      check("last_a", {31'd0, bus_a.out_last}, ((n_acc % BL) == BL - 1) ? 32'd1 : 32'd0);
      check("first_b", {31'd0, bus_b.out_first}, 32'd1);
      check("last_b", {31'd0, bus_b.out_last}, 32'd1);
    end else begin
      check("first_idle", {31'd0, bus_a.out_first}, 32'd0);
      check("last_idle", {31'd0, bus_a.out_last}, 32'd0);
    end
    if (rd_en_a && empty) underflow++;
    if (rd_en_a && (first_rd < 0)) first_rd = cyc;
    if (bus_a.out_valid && (first_val < 0)) first_val = cyc;
    if (bus_a.out_valid && out_ready) begin
      obs_acc++;
      if (bus_a.out_last) obs_last++;
    end
    @(posedge rd_clk);
    #1;
    cyc++;
    if (!rst) begin
      if (acc) begin
        void'(exp_q.pop_front());
        if ((n_acc % BL) == BL - 1) n_last++;
        n_acc++;
      end
      vis  = vis + pend - (acc ? 1 : 0);
      pend = exp_rd ? 1 : 0;
    end
    if (!rst && exp_rd) begin
      rdata = fifo_q.pop_front();
      exp_q.push_back(rdata);
    end else begin
      rdata = 8'($urandom);
    end
    @(negedge rd_clk);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; underflow = 0; cyc = 0;
    obs_acc = 0; obs_last = 0; first_rd = -1; first_val = -1;
    model_reset();
    #2 rst = 1'b1;
    @(negedge rd_clk);
    repeat (2) tick();
    check("rst_data", {24'd0, bus_a.out_data}, 32'd0);

    // Preloaded 0x11..0x18 streamed at full rate
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h11 + i));
    drain_en = 1'b1; out_ready = 1'b1; rst = 1'b0;
    rel_cyc = cyc; first_rd = -1; first_val = -1;
    repeat (12) tick();
    check("first_rd_cycle", first_rd, rel_cyc);
    check("first_latency", first_val - first_rd, 32'd2);
    check("p1_beats", obs_acc, 32'd8);
    check("p1_lasts", obs_last, 32'd2);

    // Backpressure with six words waiting, then two more after release
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'($urandom));
    out_ready = 1'b0;
    repeat (5) tick();
    check("stall_held", obs_acc, 32'd8);
    for (int i = 0; i < 2; i++) fifo_q.push_back(8'($urandom));
    out_ready = 1'b1;
    repeat (12) tick();
    check("p2_beats", obs_acc, 32'd16);

    // FIFO runs dry after two beats of a burst, then two more words finish it
    for (int i = 0; i < 2; i++) fifo_q.push_back(8'($urandom));
    repeat (11) tick();
    check("starve_lasts", obs_last, 32'd4);
    for (int i = 0; i < 2; i++) fifo_q.push_back(8'($urandom));
    repeat (6) tick();
    check("p3_beats", obs_acc, 32'd20);
    check("p3_lasts", obs_last, 32'd5);

    // drain_en dropped with words buffered and one in flight
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'($urandom));
    out_ready = 1'b0;
    repeat (2) tick();
    drain_en = 1'b0;
    repeat (2) tick();
    out_ready = 1'b1;
    repeat (6) tick();
    check("drain_beats", obs_acc, 32'd22);
    drain_en = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      if (($urandom_range(0, 2) == 0) && (fifo_q.size() < 16)) fifo_q.push_back(8'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      drain_en  = ($urandom_range(0, 7) != 0);
      tick();
    end

    // Reset while the skid buffer is full
    drain_en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'($urandom));
    repeat (4) tick();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0; out_ready = 1'b1;
    repeat (10) tick();

    // Three single words through the burst-of-one drain after a fresh reset
    rst = 1'b1;
    model_reset();
    fifo_q.delete();
    tick();
    rst = 1'b0;
    acc_mark = obs_acc;
    for (int i = 0; i < 3; i++) fifo_q.push_back(8'($urandom));
    repeat (8) tick();
    check("b1_beats", obs_acc - acc_mark, 32'd3);
    check("underflow", underflow, 32'd0);
`ifdef FIFO_RD_DRAIN_STATS_EN
    check("beat_total_b", beat_total_b, 32'd3);
    check("burst_total_b", {16'd0, burst_total_b}, 32'd3);
    check("beat_total_a", beat_total_a, n_acc);
    check("burst_total_a", {16'd0, burst_total_a}, n_last);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
